// File: rtl/duty_tx_pkg.sv
// duty_tx_pkg: shared types and constants for the duty-cycle transmitter.
//   state_t       - handshake FSM state encoding (IDLE, REQ_HI, REQ_LO)
//   DEFAULT_WIDTH - default duty-cycle sample width
package duty_tx_pkg;

  localparam int DEFAULT_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy count.
// Ports:
//   clk, rst - clock and asynchronous active-high reset
//   wr_en    - push request; ignored while full
//   wr_data  - data to push
//   rd_en    - pop request; ignored while empty
//   rd_data  - current head entry (valid while count != 0)
//   full     - high when count == DEPTH
//   count    - number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             push_s;
  logic             pop_s;

  // Accept/pop qualification and next pointer/count values. Full is taken
  // from the registered flag, so a write in the same cycle as a pop of a
  // full FIFO is still dropped.
  always_comb begin
    push_s   = wr_en && !full_q;
    pop_s    = rd_en && (count_q != {CW{1'b0}});
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    full_d = (count_d == DEPTH_CNT);
  end

  // Pointer, count and full-flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // Sample storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign count   = count_q;

endmodule

// File: rtl/synchronizer.sv
// synchronizer: multi-flop level synchronizer for a single asynchronous bit.
// Ports:
//   clk - destination clock
//   rst - asynchronous active-high reset, clears every stage
//   d   - asynchronous input level
//   q   - synchronized level, STAGES cycles of latency
module synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the input level one stage deeper each cycle.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Synchronizer stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{1'b0}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/duty_cycle_tx.sv
// duty_cycle_tx: buffers CPU-written duty-cycle samples and releases one per
// sample period to a DAC in another clock domain via a four-phase req/ack
// handshake.
// Ports:
//   clk            - CPU clock, the only clock of this block
//   rst            - asynchronous active-high reset
//   wr_en, wr_data - MMIO sample write; dropped while full
//   full, count    - FIFO full flag and occupancy
//   duty_cycle     - sample presented to the DAC, stable during handshake
//   req            - handshake request to the DAC
//   ack            - DAC acknowledge, asynchronous; synchronized internally
//   underrun_count - (only with DUTY_CYCLE_TX_UNDERRUN_CNT_EN) saturating
//                    count of sample ticks that found the FIFO empty
// Optional feature macro: DUTY_CYCLE_TX_UNDERRUN_CNT_EN
module duty_cycle_tx
  import duty_tx_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int FIFO_DEPTH    = 8,
  parameter int SAMPLE_PERIOD = 1134
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [WIDTH-1:0]              wr_data,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic [WIDTH-1:0]              duty_cycle,
  output logic                          req,
  input  logic                          ack
`ifdef DUTY_CYCLE_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                   underrun_count
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [PW-1:0] PERIOD_ONE  = PW'(1);

  logic             ack_s;
  logic [PW-1:0]    period_q, period_d;
  logic             tick_s;
  logic             pop_s;
  logic [WIDTH-1:0] head_s;
  logic             full_s;
  logic [CW-1:0]    count_s;
  logic             has_data_s;
  state_t           state_q, state_d;
  logic             req_q, req_d;
  logic [WIDTH-1:0] duty_q, duty_d;

  synchronizer #(
    .STAGES (2)
  ) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (ack),
    .q   (ack_s)
  );

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop_s),
    .rd_data (head_s),
    .full    (full_s),
    .count   (count_s)
  );

  // Registered count means a write landing this cycle is not yet visible.
  assign has_data_s = (count_s != {CW{1'b0}});

  // Sample-period counter; tick marks the last cycle of each period.
  always_comb begin
    tick_s = (period_q == PERIOD_LAST);
    if (tick_s) begin
      period_d = {PW{1'b0}};
    end else begin
      period_d = period_q + PERIOD_ONE;
    end
  end

  // Handshake FSM next-state and output logic. Ticks outside IDLE are
  // simply not looked at, so they are neither serviced nor remembered.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    duty_d  = duty_q;
    pop_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick_s && has_data_s) begin
          pop_s   = 1'b1;
          duty_d  = head_s;
          req_d   = 1'b1;
          state_d = REQ_HI;
        end else begin
          state_d = IDLE;
        end
      end
      REQ_HI: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = REQ_LO;
        end else begin
          state_d = REQ_HI;
        end
      end
      REQ_LO: begin
        if (!ack_s) begin
          state_d = IDLE;
        end else begin
          state_d = REQ_LO;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Period counter and FSM/output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q <= {PW{1'b0}};
      state_q  <= IDLE;
      req_q    <= 1'b0;
      duty_q   <= {WIDTH{1'b0}};
    end else begin
      period_q <= period_d;
      state_q  <= state_d;
      req_q    <= req_d;
      duty_q   <= duty_d;
    end
  end

  assign full       = full_s;
  assign count      = count_s;
  assign req        = req_q;
  assign duty_cycle = duty_q;

`ifdef DUTY_CYCLE_TX_UNDERRUN_CNT_EN
  logic        underrun_s;
  logic [15:0] urun_q, urun_d;

  assign underrun_s = (state_q == IDLE) && tick_s && !has_data_s;

  // Saturating underrun counter.
  always_comb begin
    if (underrun_s && (urun_q != 16'hFFFF)) begin
      urun_d = urun_q + 16'd1;
    end else begin
      urun_d = urun_q;
    end
  end

  // Underrun counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      urun_q <= 16'd0;
    end else begin
      urun_q <= urun_d;
    end
  end

  assign underrun_count = urun_q;
`endif

endmodule

// File: tb/tb_duty_cycle_tx.sv
`timescale 1ns/1ps
module tb_duty_cycle_tx;
  import duty_tx_pkg::*;

  localparam int WIDTH  = 12;
  localparam int DEPTH  = 8;
  localparam int PERIOD = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [11:0] wr_data = 12'h000;
  logic        full;
  logic [3:0]  count;
  logic [11:0] duty_cycle;
  logic        req;
  logic        ack = 1'b0;
`ifdef DUTY_CYCLE_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_count;
`endif

  int tests = 0;
  int fails = 0;

  logic [11:0] sb_q[$];
  int          pc_m = 0;
  logic [2:0]  req_pipe = 3'b000;
  logic        ack_s1_m = 1'b0;
  logic        ack_s_m = 1'b0;
  logic        dac_stall = 1'b0;
  logic        ack_force = 1'b0;

  duty_cycle_tx #(
    .WIDTH         (WIDTH),
    .FIFO_DEPTH    (DEPTH),
    .SAMPLE_PERIOD (PERIOD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .full           (full),
    .count          (count),
    .duty_cycle     (duty_cycle),
    .req            (req),
    .ack            (ack)
`ifdef DUTY_CYCLE_TX_UNDERRUN_CNT_EN
    ,
    .underrun_count (underrun_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference period counter: pc_m == PERIOD-1 marks a tick cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) pc_m <= 0;
    else     pc_m <= (pc_m == PERIOD - 1) ? 0 : pc_m + 1;
  end

  // DAC model: ack follows req a few cycles later, can stall or be forced.
  always @(posedge clk or posedge rst) begin
    if (rst) req_pipe <= 3'b000;
    else     req_pipe <= {req_pipe[1:0], req};
  end
  always @(posedge clk) begin
    ack <= ack_force ? 1'b1 : (dac_stall ? 1'b0 : req_pipe[2]);
  end

  // Reference model of the two-flop ack synchronizer.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_s1_m <= 1'b0;
      ack_s_m  <= 1'b0;
    end else begin
      ack_s1_m <= ack;
      ack_s_m  <= ack_s1_m;
    end
  end

  // Scoreboard monitor: each req rise must carry the oldest accepted sample,
  // and duty_cycle must not move while req is high.
  initial begin : monitor
    logic        req_prev;
    logic [11:0] held;
    logic [11:0] exp_v;
    req_prev = 1'b0;
    held     = 12'h000;
    forever begin
      @(negedge clk);
      if (rst) begin
        req_prev = 1'b0;
      end else begin
        if (req && !req_prev) begin
          tests++;
          if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_req: req rose with duty_cycle=%h, required no handshake", duty_cycle);
          end else begin
            exp_v = sb_q.pop_front();
            if (duty_cycle !== exp_v) begin
              fails++;
              $display("FAIL sample_order: duty_cycle=%h, required %h", duty_cycle, exp_v);
            end
          end
          held = duty_cycle;
        end else if (req) begin
          tests++;
          if (duty_cycle !== held) begin
            fails++;
            $display("FAIL duty_stable: duty_cycle=%h while req high, required %h", duty_cycle, held);
          end
        end
        req_prev = req;
      end
    end
  end

  task automatic do_write(input logic [11:0] data);
    wr_en   = 1'b1;
    wr_data = data;
    if (sb_q.size() < DEPTH) sb_q.push_back(data);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Advance to the next negedge where the reference counter equals target.
  task automatic wait_pc(input int target);
    int n;
    n = 0;
    @(negedge clk);
    while (pc_m != target && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (pc_m != target) begin
      tests++;
      fails++;
      $display("FAIL wait_pc: counter=%0d after timeout, required %0d", pc_m, target);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d samples never delivered, required 0", sb_q.size());
    end
    n = 0;
    while (req !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (req !== 1'b0) begin
      fails++;
      $display("FAIL drain_req: req=%b after timeout, required 0", req);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (req !== 1'b0) begin fails++; $display("FAIL reset_req: req=%b, required 0", req); end
    tests++; if (duty_cycle !== 12'h000) begin fails++; $display("FAIL reset_duty: duty_cycle=%h, required 000", duty_cycle); end
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count: count=%0d, required 0", count); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full: full=%b, required 0", full); end
`ifdef DUTY_CYCLE_TX_UNDERRUN_CNT_EN
    tests++; if (underrun_count !== 16'd0) begin fails++; $display("FAIL reset_underrun: underrun_count=%0d, required 0", underrun_count); end
`endif
    rst = 1'b0;
    sb_q.delete();
  endtask

  task automatic test_single();
    int n;
    do_write(12'h800);
    wait_pc(PERIOD - 1);
    tests++; if (req !== 1'b0) begin fails++; $display("FAIL single_pre_tick: req=%b, required 0", req); end
    @(negedge clk);
    tests++; if (req !== 1'b1) begin fails++; $display("FAIL single_req_rise: req=%b, required 1", req); end
    tests++; if (duty_cycle !== 12'h800) begin fails++; $display("FAIL single_duty: duty_cycle=%h, required 800", duty_cycle); end
    n = 0;
    while (!ack_s_m && n < 32) begin @(negedge clk); n++; end
    tests++; if (req !== 1'b1) begin fails++; $display("FAIL single_req_hold: req=%b at ack_s rise, required 1", req); end
    @(negedge clk);
    tests++; if (req !== 1'b0) begin fails++; $display("FAIL single_req_fall: req=%b, required 0", req); end
    n = 0;
    while (ack_s_m && n < 32) begin @(negedge clk); n++; end
    tests++; if (dut.state_q !== REQ_LO) begin fails++; $display("FAIL single_req_lo: state=%0d, required %0d", dut.state_q, REQ_LO); end
    @(negedge clk);
    tests++; if (dut.state_q !== IDLE) begin fails++; $display("FAIL single_idle: state=%0d, required %0d", dut.state_q, IDLE); end
  endtask

  task automatic test_fill();
    wait_pc(0);
    for (int i = 1; i <= 9; i++) begin
      do_write(12'(i));
      if (i == 8) begin
        tests++; if (full !== 1'b1) begin fails++; $display("FAIL fill_full: full=%b after 8 writes, required 1", full); end
      end
    end
    tests++; if (count !== 4'd8) begin fails++; $display("FAIL fill_count: count=%0d, required 8", count); end
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL fill_drop: full=%b after 9th write, required 1", full); end
  endtask

  task automatic test_full_pop();
    wait_pc(PERIOD - 1);
    wr_en   = 1'b1;
    wr_data = 12'hABC;
    @(negedge clk);
    wr_en = 1'b0;
    tests++; if (count !== 4'd7) begin fails++; $display("FAIL full_pop_count: count=%0d, required 7", count); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL full_pop_full: full=%b, required 0", full); end
    drain();
  endtask

  task automatic test_stall();
    dac_stall = 1'b1;
    wait_pc(2);
    do_write(12'h3C5);
    do_write(12'h0F0);
    wait_pc(PERIOD - 1);
    @(negedge clk);
    tests++; if (req !== 1'b1) begin fails++; $display("FAIL stall_start: req=%b, required 1", req); end
    for (int k = 0; k < 3; k++) begin
      wait_pc(PERIOD - 1);
      @(negedge clk);
      tests++; if (req !== 1'b1) begin fails++; $display("FAIL stall_req: req=%b at tick %0d, required 1", req, k); end
      tests++; if (duty_cycle !== 12'h3C5) begin fails++; $display("FAIL stall_duty: duty_cycle=%h, required 3c5", duty_cycle); end
      tests++; if (count !== 4'd1) begin fails++; $display("FAIL stall_count: count=%0d, required 1", count); end
    end
    dac_stall = 1'b0;
    drain();
  endtask

  task automatic test_underrun();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    do_write(12'h5A5);
    wait_pc(PERIOD - 1);
    @(negedge clk);
    for (int k = 1; k <= 5; k++) begin
      wait_pc(PERIOD - 1);
      @(negedge clk);
      tests++; if (req !== 1'b0) begin fails++; $display("FAIL underrun_req: req=%b at tick %0d, required 0", req, k); end
      tests++; if (duty_cycle !== 12'h5A5) begin fails++; $display("FAIL underrun_duty: duty_cycle=%h, required 5a5", duty_cycle); end
`ifdef DUTY_CYCLE_TX_UNDERRUN_CNT_EN
      tests++; if (underrun_count !== 16'(k)) begin fails++; $display("FAIL underrun_count: underrun_count=%0d, required %0d", underrun_count, k); end
`endif
    end
  endtask

  task automatic test_reset_mid();
    do_write(12'h7E1);
    wait_pc(PERIOD - 1);
    @(negedge clk);
    tests++; if (req !== 1'b1) begin fails++; $display("FAIL rstmid_req_hi: req=%b, required 1", req); end
    #1 rst = 1'b1;
    #1;
    tests++; if (req !== 1'b0) begin fails++; $display("FAIL rstmid_req: req=%b during reset, required 0", req); end
    tests++; if (duty_cycle !== 12'h000) begin fails++; $display("FAIL rstmid_duty: duty_cycle=%h during reset, required 000", duty_cycle); end
    ack_force = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    for (int k = 0; k < 3; k++) begin
      wait_pc(PERIOD - 1);
      @(negedge clk);
      tests++; if (req !== 1'b0) begin fails++; $display("FAIL rstmid_no_hs: req=%b at tick %0d, required 0", req, k); end
    end
    ack_force = 1'b0;
    repeat (6) @(negedge clk);
    do_write(12'h123);
    wait_pc(PERIOD - 1);
    @(negedge clk);
    tests++; if (req !== 1'b1) begin fails++; $display("FAIL rstmid_resume: req=%b, required 1", req); end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_pop();
    test_stall();
    test_underrun();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/duty_cycle_tx.md
DUTY_CYCLE_TX -- requirements
Module: duty_cycle_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 12, duty-cycle sample width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8 (power of two), number of buffered samples.
REQ-003 SHALL have parameter SAMPLE_PERIOD, default 1134, cpu_clk cycles per sample release (~44.1 kHz at 50 MHz).
REQ-004 SHALL have port clk, input, 1, CPU clock; the block's only clock.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port wr_en, input, 1, CPU MMIO sample write strobe.
REQ-007 SHALL have port wr_data, input, WIDTH, sample to enqueue.
REQ-008 SHALL have port full, output, 1, FIFO full; writes while high are dropped.
REQ-009 SHALL have port count, output, $clog2(FIFO_DEPTH)+1, FIFO occupancy.
REQ-010 SHALL have port duty_cycle, output, WIDTH, sample presented to the dac.
REQ-011 SHALL have port req, output, 1, four-phase handshake request to the dac.
REQ-012 SHALL have port ack, input, 1, dac acknowledge, asynchronous to clk (PWM domain).

Function
REQ-013 SHALL synchronize ack through two flops; only ack_s drives the FSM.
REQ-014 SHALL run a period counter 0..SAMPLE_PERIOD-1, wrapping to 0, asserting tick for one cycle at SAMPLE_PERIOD-1.
REQ-015 SHALL use FSM states IDLE, REQ_HI, REQ_LO.
REQ-016 IDLE: on tick with count>0, pop the FIFO head into duty_cycle and enter REQ_HI; duty_cycle and req=1 are visible on the next cycle.
REQ-017 REQ_HI: hold req=1 and duty_cycle stable; when ack_s=1, go to REQ_LO with req=0 on the next cycle.
REQ-018 REQ_LO: hold duty_cycle stable; when ack_s=0, return to IDLE on the next cycle.
REQ-019 Tick in IDLE with count=0 (underrun) SHALL leave duty_cycle unchanged and start no handshake.
REQ-020 Tick in REQ_HI or REQ_LO SHALL be ignored; no pop and no queuing of the tick.
REQ-021 SHALL enqueue on wr_en when full=0; wr_en when full=1 SHALL be dropped with no state change.
REQ-022 SHALL evaluate full before a same-cycle pop, so a write during a pop while full is dropped.
REQ-023 A write to an empty FIFO SHALL not be poppable in the same cycle; it is eligible from the next tick.
REQ-024 full SHALL equal (count==FIFO_DEPTH); read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-025 On rst SHALL immediately set req=0, duty_cycle=0, count=0, full=0, state=IDLE, period counter=0, sync flops=0, and pointers=0.
REQ-026 rst mid-handshake SHALL abandon the transfer; after release the FSM SHALL start from IDLE regardless of the ack level.

Configuration
REQ-027 With DUTY_CYCLE_TX_UNDERRUN_CNT_EN defined, SHALL add output underrun_count[15:0], reset 0, incremented on each REQ-019 underrun tick and saturating at 16'hFFFF.
REQ-028 Without DUTY_CYCLE_TX_UNDERRUN_CNT_EN, SHALL omit the port and its counter; all other behaviour is identical.

Structure
REQ-029 Package duty_tx_pkg SHALL hold the FSM state enum and the default WIDTH constant.
REQ-030 Sample storage SHALL be a sub-module sync_fifo (single-clock, registered count); ack sync SHALL reuse the existing synchronizer module.

Verification (SAMPLE_PERIOD=16, FIFO_DEPTH=8, dac model acks 3 cycles after req edges)
REQ-031 Write 12'h800, then wait for a tick -> req rises the cycle after the tick with duty_cycle=12'h800, falls 1 cycle after ack_s=1, FSM returns to IDLE 1 cycle after ack_s=0.
REQ-032 Write 9 samples 1..9 with no tick -> full=1 after the 8th write, sample 9 dropped, count=8; on successive ticks the dac receives 1..8 in order.
REQ-033 Hold ack low (stalled dac) across 3 ticks -> req stays 1, duty_cycle stable, count unchanged, no extra pops.
REQ-034 Empty FIFO over 5 ticks -> req stays 0, duty_cycle holds last value, underrun_count=5 with the macro defined; port absent without it.
REQ-035 Assert rst while in REQ_HI -> req=0 and duty_cycle=0 in the same cycle; after release with ack=1, no handshake occurs until a new write and a tick.
REQ-036 Write at the same cycle as the pop of a full FIFO -> write dropped and count=7.
